// File: rtl/mod_n_counter.sv
// Parametrised modulo-N up/down counter: sync clear/load, wrap or saturate, terminal count, wrap pulse.
// Define MOD_N_COUNTER_CMP_EN to add the cmp_lo/cmp_hi compare window and its registered match output.
module mod_n_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX      = 255,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrapped
`ifdef MOD_N_COUNTER_CMP_EN
  ,
  input  logic [WIDTH-1:0] cmp_lo,
  input  logic [WIDTH-1:0] cmp_hi,
  output logic             match
`endif
);

  localparam int unsigned      EXT_W  = WIDTH + 1;
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ZERO_W = '0;
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] w_out_next;
  logic [WIDTH-1:0] w_load_clamped;
  logic             r_wrapped;
  logic             w_wrapped_next;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_boundary;

  // Boundary for the currently requested direction; tc feeds the next stage's enable.
  assign w_at_max   = (r_out == MAX_W);
  assign w_at_zero  = (r_out == ZERO_W);
  assign w_boundary = up_down ? w_at_max : w_at_zero;
  assign tc         = enable & w_boundary;

  // Compared one bit wider so MAX == 2**WIDTH-1 is not a degenerate compare.
  assign w_load_clamped = ({1'b0, load_value} > EXT_W'(MAX)) ? MAX_W : load_value;

  // Next count: clear beats load beats enable; no action holds and drops the wrap pulse.
  always_comb begin
    w_out_next     = r_out;
    w_wrapped_next = 1'b0;
    if (clear) begin
      w_out_next = ZERO_W;
    end else if (load) begin
      w_out_next = w_load_clamped;
    end else if (enable) begin
      if (w_boundary) begin
        w_wrapped_next = 1'b1;
        if (!SATURATE) begin
          w_out_next = up_down ? ZERO_W : MAX_W;
        end
      end else begin
        w_out_next = up_down ? (r_out + ONE_W) : (r_out - ONE_W);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out     <= ZERO_W;
      r_wrapped <= 1'b0;
    end else begin
      r_out     <= w_out_next;
      r_wrapped <= w_wrapped_next;
    end
  end

  assign out     = r_out;
  assign wrapped = r_wrapped;

`ifdef MOD_N_COUNTER_CMP_EN
  logic r_match;
  logic w_match_next;

  // Evaluated on the incoming count so match lines up with out; an empty window never matches.
  assign w_match_next = (cmp_lo <= w_out_next) && (w_out_next < cmp_hi);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_match <= 1'b0;
    end else begin
      r_match <= w_match_next;
    end
  end

  assign match = r_match;
`endif

endmodule

// File: tb/tb_mod_n_counter.sv
// Bench for mod_n_counter: wrap and saturate instances (WIDTH=8, MAX=9) against an arithmetic reference model.
module tb_mod_n_counter;

  localparam int unsigned WIDTH = 8;
  localparam int          MAX   = 9;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             clear;
  logic [WIDTH-1:0] out_w, out_s;
  logic             tc_w, tc_s;
  logic             wr_w, wr_s;
`ifdef MOD_N_COUNTER_CMP_EN
  logic [WIDTH-1:0] cmp_lo, cmp_hi;
  logic             match_w, match_s;
  bit               mm_w, mm_s;
`endif

  int n_pass   = 0;
  int n_checks = 0;
  int m_w, m_s;
  bit mwr_w, mwr_s;

  always #5 clk = ~clk;

  mod_n_counter #(.WIDTH(WIDTH), .MAX(MAX), .SATURATE(1'b0)) dut_w (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value), .clear(clear), .out(out_w), .tc(tc_w), .wrapped(wr_w)
`ifdef MOD_N_COUNTER_CMP_EN
    , .cmp_lo(cmp_lo), .cmp_hi(cmp_hi), .match(match_w)
`endif
  );

  mod_n_counter #(.WIDTH(WIDTH), .MAX(MAX), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value), .clear(clear), .out(out_s), .tc(tc_s), .wrapped(wr_s)
`ifdef MOD_N_COUNTER_CMP_EN
    , .cmp_lo(cmp_lo), .cmp_hi(cmp_hi), .match(match_s)
`endif
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: count lives on the ring 0..MAX; saturate clips the raw step instead of folding it.
  function automatic void model_step(input bit sat, input int cnt, output int nc, output bit wr);
    int t;
    nc = cnt;
    wr = 1'b0;
    if (clear) begin
      nc = 0;
    end else if (load) begin
      nc = (int'(load_value) > MAX) ? MAX : int'(load_value);
    end else if (enable) begin
      t  = up_down ? cnt + 1 : cnt - 1;
      wr = (t > MAX) || (t < 0);
      if (sat) nc = (t > MAX) ? MAX : ((t < 0) ? 0 : t);
      else     nc = (t + MAX + 1) % (MAX + 1);
    end
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_out_wrap"}, int'(out_w), 0);
    check({tag, "_out_sat"},  int'(out_s), 0);
    check({tag, "_wrapped_wrap"}, int'(wr_w), 0);
    check({tag, "_wrapped_sat"},  int'(wr_s), 0);
`ifdef MOD_N_COUNTER_CMP_EN
    check({tag, "_match_wrap"}, int'(match_w), 0);
    check({tag, "_match_sat"},  int'(match_s), 0);
`endif
  endtask

  task automatic cycle(input bit en, input bit ud, input bit ld, input int lv, input bit clr);
    int nw, ns;
    bit ww, ws;
    @(negedge clk);
    enable     = en;
    up_down    = ud;
    load       = ld;
    load_value = 8'(lv);
    clear      = clr;
    #1;
    check("tc_wrap", int'(tc_w), int'(en && (ud ? (m_w == MAX) : (m_w == 0))));
    check("tc_sat",  int'(tc_s), int'(en && (ud ? (m_s == MAX) : (m_s == 0))));
    model_step(1'b0, m_w, nw, ww);
    model_step(1'b1, m_s, ns, ws);
`ifdef MOD_N_COUNTER_CMP_EN
    mm_w = (int'(cmp_lo) <= nw) && (nw < int'(cmp_hi));
    mm_s = (int'(cmp_lo) <= ns) && (ns < int'(cmp_hi));
`endif
    m_w = nw; m_s = ns; mwr_w = ww; mwr_s = ws;
    @(posedge clk);
    #1;
    check("out_wrap", int'(out_w), m_w);
    check("out_sat",  int'(out_s), m_s);
    check("wrapped_wrap", int'(wr_w), int'(mwr_w));
    check("wrapped_sat",  int'(wr_s), int'(mwr_s));
`ifdef MOD_N_COUNTER_CMP_EN
    check("match_wrap", int'(match_w), int'(mm_w));
    check("match_sat",  int'(match_s), int'(mm_s));
`endif
  endtask

  // Asserts reset between clock edges, checks the immediate effect, then releases it on a falling edge.
  task automatic async_reset(input string tag);
    #2;
    reset  = 1'b0;
    enable = 1'b0;
    load   = 1'b0;
    clear  = 1'b0;
    #1;
    check_all_zero(tag);
    m_w = 0; m_s = 0; mwr_w = 1'b0; mwr_s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero({tag, "_held"});
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; up_down = 1'b1; load = 1'b0; clear = 1'b0; load_value = '0;
`ifdef MOD_N_COUNTER_CMP_EN
    cmp_lo = '0; cmp_hi = '0; mm_w = 1'b0; mm_s = 1'b0;
`endif
    m_w = 0; m_s = 0; mwr_w = 1'b0; mwr_s = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Up count through the wrap: 1..9,0,1,2
    repeat (12) cycle(1'b1, 1'b1, 1'b0, 0, 1'b0);
    // Up to 5, then asynchronous reset mid-count
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 0, 1'b0);
    check("pre_reset_out", int'(out_w), 5);
    async_reset("rst_mid");

    // Down from 1: 0,9,8
    cycle(1'b1, 1'b1, 1'b0, 0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);

    // Load clamping and clear-over-load
    cycle(1'b1, 1'b1, 1'b1, 200, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 4, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 9, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 255, 1'b0);

    // Saturation at the top, then reset while the wrap pulse is high
    cycle(1'b0, 1'b1, 1'b1, 8, 1'b0);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 0, 1'b0);
    check("sat_pulse_high", int'(wr_s), 1);
    async_reset("rst_wrapped");

    // Hold with enable low, then saturation at the bottom
    cycle(1'b0, 1'b1, 1'b1, 9, 1'b0);
    repeat (2) cycle(1'b0, 1'b1, 1'b0, 0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);

`ifdef MOD_N_COUNTER_CMP_EN
    // Compare window [2,5) while counting up, then an empty window
    cmp_lo = 8'd2; cmp_hi = 8'd5;
    cycle(1'b0, 1'b1, 1'b0, 0, 1'b1);
    repeat (11) cycle(1'b1, 1'b1, 1'b0, 0, 1'b0);
    cmp_lo = 8'd6; cmp_hi = 8'd6;
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 0, 1'b0);
`endif

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
`ifdef MOD_N_COUNTER_CMP_EN
      cmp_lo = 8'($urandom_range(0, 11));
      cmp_hi = 8'($urandom_range(0, 11));
`endif
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
            int'($urandom_range(0, 255)), $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
